// File: rtl/knight_pkg.sv
// Shared types and constants for the BLE/UART command link and the command processor.
package knight_pkg;

    // Receive side: waiting for the high byte or for the low byte of a command.
    typedef enum logic {
        RX_HI = 1'b0,
        RX_LO = 1'b1
    } rx_state_t;

    // Acknowledge transmit side.
    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    // Command opcodes, carried in cmd[15:12].
    typedef enum logic [3:0] {
        CAL     = 4'h0,
        MOVE    = 4'h2,
        MOVE_FF = 4'h3,
        TOUR    = 4'h4
    } opcode_t;

    localparam logic [7:0] ACK_BYTE  = 8'hA5;
    localparam int         GAP_FAST  = 4096;
    localparam int         GAP_SLOW  = 2_500_000;
    localparam int         GAP_CNT_W = 22;

    // Last gap_cnt value before the half-received command is abandoned.
    function automatic logic [GAP_CNT_W-1:0] gap_last(input bit fast);
        return fast ? GAP_CNT_W'(GAP_FAST - 1) : GAP_CNT_W'(GAP_SLOW - 1);
    endfunction

endpackage

// File: rtl/resp_tx_ctrl.sv
// Acknowledge transmit control: launches the response byte on request and queues
// at most one further request while the transmitter is busy.
import knight_pkg::*;

module resp_tx_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic send_resp,
    input  logic tx_done,
    output logic trmt,
    output logic tx_busy
);

    tx_state_t tx_state;
    logic      pend;

    // Start pulse is Mealy so a request launches in the cycle it arrives.
    always_comb begin
        trmt = 1'b0;
        if (!rst) begin
            case (tx_state)
                TX_IDLE: trmt = send_resp;
                TX_BUSY: trmt = tx_done && (pend || send_resp);
                default: trmt = 1'b0;
            endcase
        end
    end

    // TX state and one-deep pending request; extra requests while pending are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            pend     <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (send_resp)
                        tx_state <= TX_BUSY;
                end
                TX_BUSY: begin
                    if (tx_done) begin
                        pend <= 1'b0;
                        if (!(pend || send_resp))
                            tx_state <= TX_IDLE;
                    end else if (send_resp) begin
                        pend <= 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    pend     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_busy = (tx_state == TX_BUSY) || pend;

endmodule

// File: rtl/cmd_rx_wrapper.sv
// Bridge between the UART byte link and the command processor: assembles two-byte
// commands (high byte first), flags overwrites and inter-byte timeouts, and sends
// a one-byte acknowledge on request.
import knight_pkg::*;

module cmd_rx_wrapper #(
    parameter bit         FAST_SIM  = 1'b1,
    parameter logic [7:0] RESP_BYTE = ACK_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        cmd_ovr,
    output logic        frame_err,
    input  logic        send_resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        tx_busy
);

    localparam logic [GAP_CNT_W-1:0] GAP_LAST = gap_last(FAST_SIM);

    rx_state_t            rx_state;
    logic [7:0]           hi_byte;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic                 accept;
    logic                 assemble;
    logic                 timeout;

    // Byte consumption, assembly and timeout decode; all pulses are suppressed during reset.
    always_comb begin
        accept   = !rst && rx_rdy;
        assemble = accept && (rx_state == RX_LO);
        // A byte arriving on the last gap cycle still completes the command.
        timeout  = !rst && (rx_state == RX_LO) && !rx_rdy && (gap_cnt == GAP_LAST);
    end

    assign clr_rx_rdy = accept;
    assign frame_err  = timeout;
    assign cmd_ovr    = assemble && cmd_rdy && !clr_cmd_rdy;

    // RX FSM with the held high byte, the inter-byte gap counter and the cmd register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_HI;
            hi_byte  <= 8'h00;
            gap_cnt  <= '0;
            cmd      <= 16'h0000;
        end else begin
            case (rx_state)
                RX_HI: begin
                    if (rx_rdy) begin
                        hi_byte  <= rx_data;
                        gap_cnt  <= '0;
                        rx_state <= RX_LO;
                    end
                end
                RX_LO: begin
                    // The state always leaves before the counter could wrap.
                    gap_cnt <= gap_cnt + GAP_CNT_W'(1);
                    if (rx_rdy) begin
                        cmd      <= {hi_byte, rx_data};
                        rx_state <= RX_HI;
                    end else if (timeout) begin
                        rx_state <= RX_HI;
                    end
                end
                default: rx_state <= RX_HI;
            endcase
        end
    end

    // cmd_rdy: a new command wins over a same-cycle clear from the processor.
    always_ff @(posedge clk) begin
        if (rst)
            cmd_rdy <= 1'b0;
        else if (assemble)
            cmd_rdy <= 1'b1;
        else if (clr_cmd_rdy)
            cmd_rdy <= 1'b0;
    end

    assign tx_data = RESP_BYTE;

    resp_tx_ctrl u_resp_tx_ctrl (
        .clk       (clk),
        .rst       (rst),
        .send_resp (send_resp),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_busy   (tx_busy)
    );

endmodule

// File: tb/tb_cmd_rx_wrapper.sv
// Directed bench for cmd_rx_wrapper: per-cycle vector table plus timeout sequences.
module tb_cmd_rx_wrapper;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        cmd_ovr;
    logic        frame_err;
    logic        send_resp;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        tx_busy;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    cmd_rx_wrapper #(.FAST_SIM(1'b1), .RESP_BYTE(8'hA5)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_ovr     (cmd_ovr),
        .frame_err   (frame_err),
        .send_resp   (send_resp),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .tx_busy     (tx_busy)
    );

    typedef struct {
        logic        rst;
        logic        rx_rdy;
        logic [7:0]  rx_data;
        logic        ccr;
        logic        sr;
        logic        td;
        logic        e_clr;
        logic [15:0] e_cmd;
        logic        e_rdy;
        logic        e_ovr;
        logic        e_ferr;
        logic        e_trmt;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rr, input logic [7:0] d,
                                input logic ccr, input logic sr, input logic td,
                                input logic e_clr, input logic [15:0] e_cmd,
                                input logic e_rdy, input logic e_ovr, input logic e_ferr,
                                input logic e_trmt, input logic e_busy);
        vec_t v;
        v.rst = r; v.rx_rdy = rr; v.rx_data = d; v.ccr = ccr; v.sr = sr; v.td = td;
        v.e_clr = e_clr; v.e_cmd = e_cmd; v.e_rdy = e_rdy; v.e_ovr = e_ovr;
        v.e_ferr = e_ferr; v.e_trmt = e_trmt; v.e_busy = e_busy;
        return v;
    endfunction

    // Advance one cycle: drive just after the rising edge, return at the falling edge.
    task automatic step(input logic r, input logic rr, input logic [7:0] d,
                        input logic ccr, input logic sr, input logic td);
        @(posedge clk);
        #1;
        rst = r; rx_rdy = rr; rx_data = d; clr_cmd_rdy = ccr; send_resp = sr; tx_done = td;
        @(negedge clk);
    endtask

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        int k;
        logic seen;

        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; tx_done = 1'b0;
        repeat (2) @(posedge clk);

        //            rst rr  data  ccr sr  td   clr cmd       rdy ovr fe  trmt busy
        // Reset state, then 8'h23 and 8'h15 five cycles apart, then clear.
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0,   0, 16'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h23, 0, 0, 0,   1, 16'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h15, 0, 0, 0,   1, 16'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h2315, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0,   0, 16'h2315, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h2315, 0, 0, 0, 0, 0));
        // Overwrite: 3021 then 2040 with no clear.
        vecs.push_back(mk(0, 1, 8'h30, 0, 0, 0,   1, 16'h2315, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h21, 0, 0, 0,   1, 16'h2315, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h20, 0, 0, 0,   1, 16'h3021, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h40, 0, 0, 0,   1, 16'h3021, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h2040, 1, 0, 0, 0, 0));
        // Clear on the completion cycle: no overwrite flag.
        vecs.push_back(mk(0, 1, 8'h30, 0, 0, 0,   1, 16'h2040, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h21, 1, 0, 0,   1, 16'h2040, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h3021, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0,   0, 16'h3021, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h3021, 0, 0, 0, 0, 0));
        // Acknowledge: launch, queue one, drop a third, tx_done in idle ignored.
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0,   0, 16'h3021, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h3021, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0,   0, 16'h3021, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0,   0, 16'h3021, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   0, 16'h3021, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   0, 16'h3021, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h3021, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   0, 16'h3021, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h3021, 0, 0, 0, 0, 0));
        // Request coinciding with tx_done relaunches immediately.
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0,   0, 16'h3021, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1,   0, 16'h3021, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1,   0, 16'h3021, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h3021, 0, 0, 0, 0, 0));
        // Reset between bytes and during TX_BUSY; next byte is a high byte.
        vecs.push_back(mk(0, 1, 8'h11, 0, 0, 0,   1, 16'h3021, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0,   0, 16'h3021, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0,   0, 16'h3021, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 0, 0,   1, 16'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 0, 0,   1, 16'h0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h2233, 1, 0, 0, 0, 0));
        // Reset with cmd_rdy set clears cmd and cmd_rdy.
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0,   0, 16'h2233, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0,   0, 16'h0000, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].rx_rdy, vecs[i].rx_data,
                 vecs[i].ccr, vecs[i].sr, vecs[i].td);
            n_vec++;
            if (clr_rx_rdy !== vecs[i].e_clr || cmd !== vecs[i].e_cmd ||
                cmd_rdy !== vecs[i].e_rdy || cmd_ovr !== vecs[i].e_ovr ||
                frame_err !== vecs[i].e_ferr || trmt !== vecs[i].e_trmt ||
                tx_busy !== vecs[i].e_busy || tx_data !== 8'hA5) begin
                n_miss++;
                $display("FAIL vec%0d: got clr=%b cmd=%h rdy=%b ovr=%b ferr=%b trmt=%b busy=%b txd=%h expected clr=%b cmd=%h rdy=%b ovr=%b ferr=%b trmt=%b busy=%b txd=a5",
                         i, clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, frame_err, trmt, tx_busy, tx_data,
                         vecs[i].e_clr, vecs[i].e_cmd, vecs[i].e_rdy, vecs[i].e_ovr,
                         vecs[i].e_ferr, vecs[i].e_trmt, vecs[i].e_busy);
            end
        end

        // Lone high byte: frame_err exactly 4096 cycles after the byte cycle.
        step(0, 1, 8'h40, 0, 0, 0);
        check1("gap_hi_clr", {31'd0, clr_rx_rdy}, 32'd1);
        k = 0;
        for (int c = 1; c <= 5000; c++) begin
            step(0, 0, 8'h00, 0, 0, 0);
            if (frame_err === 1'b1) begin
                k = c;
                break;
            end
        end
        check1("gap_ferr_cycle", k, 32'd4096);
        check1("gap_cmd_kept", {16'd0, cmd}, 32'h0000);
        check1("gap_rdy_kept", {31'd0, cmd_rdy}, 32'd0);
        step(0, 0, 8'h00, 0, 0, 0);
        check1("gap_ferr_pulse", {31'd0, frame_err}, 32'd0);
        step(0, 1, 8'h00, 0, 0, 0);
        step(0, 1, 8'h00, 0, 0, 0);
        check1("gap_next_ovr", {31'd0, cmd_ovr}, 32'd0);
        step(0, 0, 8'h00, 0, 0, 0);
        check1("gap_next_cmd", {16'd0, cmd}, 32'h0000);
        check1("gap_next_rdy", {31'd0, cmd_rdy}, 32'd1);
        step(0, 0, 8'h00, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0);
        check1("gap_clr_rdy", {31'd0, cmd_rdy}, 32'd0);

        // Low byte on the timeout cycle is accepted instead of a frame error.
        step(0, 1, 8'h55, 0, 0, 0);
        seen = 1'b0;
        for (int c = 1; c < 4096; c++) begin
            step(0, 0, 8'h00, 0, 0, 0);
            if (frame_err === 1'b1) seen = 1'b1;
        end
        check1("edge_early_ferr", {31'd0, seen}, 32'd0);
        step(0, 1, 8'h66, 0, 0, 0);
        check1("edge_clr", {31'd0, clr_rx_rdy}, 32'd1);
        check1("edge_ferr", {31'd0, frame_err}, 32'd0);
        step(0, 0, 8'h00, 0, 0, 0);
        check1("edge_cmd", {16'd0, cmd}, 32'h5566);
        check1("edge_rdy", {31'd0, cmd_rdy}, 32'd1);
        check1("edge_ferr_after", {31'd0, frame_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
